// File: rtl/writeback_arbiter_pkg.sv
// Shared widths, the buffered write record and the output-source select
// used by the writeback arbiter and its completion FIFO.
package writeback_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_PIPE   = 2'd1,
    SEL_FIFO   = 2'd2,
    SEL_BYPASS = 2'd3
  } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of {rd, data} writes; exposes per-slot valid/rd so the
// hazard query can see every buffered destination at once.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  wb_entry_t                        push_entry,
  input  logic                             pop,
  output wb_entry_t                        head,
  output logic [$clog2(DEPTH):0]           count,
  output logic [DEPTH-1:0]                 entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          mem_reg [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; stale slots are masked by entry_valid.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= push_entry;
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] offset;
      assign offset          = PTR_W'(gi) - rd_ptr_reg;
      assign entry_valid[gi] = ({1'b0, offset} < count_reg);
      assign entry_rd[gi]    = mem_reg[gi].rd;
    end
  endgenerate

endmodule

// File: rtl/writeback_arbiter.sv
// Merges MEM/WB retire writes and buffered LSU completions onto the single
// register-file write port, with x0 filtering and a pending-write query.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_valid_i,
  input  logic [REG_ADDR_W-1:0] pipe_rd_i,
  input  logic [XLEN-1:0]       pipe_data_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [REG_ADDR_W-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]       lsu_data_i,
  output logic                  reg_write_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [XLEN-1:0]       write_data_o,
  output logic [$clog2(DEPTH):0] fifo_count_o,
  input  logic [REG_ADDR_W-1:0] query_addr_i,
  output logic                  query_hit_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t                        fifo_head;
  wb_entry_t                        lsu_entry;
  logic [CNT_W-1:0]                 fifo_count;
  logic [DEPTH-1:0]                 entry_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd;

  logic    pipe_eff, lsu_eff, fifo_empty, push, pop;
  wb_sel_e sel;

  logic                  out_valid_reg;
  logic [REG_ADDR_W-1:0] out_rd_reg;
  logic [XLEN-1:0]       out_data_reg;

  assign lsu_ready_o = (fifo_count < CNT_W'(DEPTH));
  assign pipe_eff    = pipe_valid_i && (pipe_rd_i != '0);
  // x0 LSU completions still handshake but are dropped here.
  assign lsu_eff     = lsu_valid_i && lsu_ready_o && (lsu_rd_i != '0);
  assign fifo_empty  = (fifo_count == '0);
  assign lsu_entry   = '{rd: lsu_rd_i, data: lsu_data_i};

  always_comb begin
    sel = SEL_NONE;
    if (pipe_eff)         sel = SEL_PIPE;
    else if (!fifo_empty) sel = SEL_FIFO;
    else if (lsu_eff)     sel = SEL_BYPASS;
  end

  assign pop  = (sel == SEL_FIFO);
  assign push = lsu_eff && (sel != SEL_BYPASS);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_entry  (lsu_entry),
    .pop         (pop),
    .head        (fifo_head),
    .count       (fifo_count),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_rd_reg    <= '0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= (sel != SEL_NONE);
      case (sel)
        SEL_PIPE: begin
          out_rd_reg   <= pipe_rd_i;
          out_data_reg <= pipe_data_i;
        end
        SEL_FIFO: begin
          out_rd_reg   <= fifo_head.rd;
          out_data_reg <= fifo_head.data;
        end
        SEL_BYPASS: begin
          out_rd_reg   <= lsu_rd_i;
          out_data_reg <= lsu_data_i;
        end
        default: ;
      endcase
    end
  end

  assign reg_write_o  = out_valid_reg;
  assign rd_addr_o    = out_rd_reg;
  assign write_data_o = out_data_reg;
  assign fifo_count_o = fifo_count;

  always_comb begin
    query_hit_o = out_valid_reg && (out_rd_reg == query_addr_i);
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_rd[i] == query_addr_i)) query_hit_o = 1'b1;
    end
    if (query_addr_i == '0) query_hit_o = 1'b0;
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed-vector bench for writeback_arbiter with hand-computed expectations.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid_i;
  logic [4:0]  pipe_rd_i;
  logic [31:0] pipe_data_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_data_i;
  logic        reg_write_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] write_data_o;
  logic [2:0]  fifo_count_o;
  logic [4:0]  query_addr_i;
  logic        query_hit_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  writeback_arbiter #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_valid_i (pipe_valid_i),
    .pipe_rd_i    (pipe_rd_i),
    .pipe_data_i  (pipe_data_i),
    .lsu_valid_i  (lsu_valid_i),
    .lsu_ready_o  (lsu_ready_o),
    .lsu_rd_i     (lsu_rd_i),
    .lsu_data_i   (lsu_data_i),
    .reg_write_o  (reg_write_o),
    .rd_addr_o    (rd_addr_o),
    .write_data_o (write_data_o),
    .fifo_count_o (fifo_count_o),
    .query_addr_i (query_addr_i),
    .query_hit_o  (query_hit_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("vec %0d %s ok (%h)", n_vec, tag, got);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_valid_i = 1'b0; pipe_rd_i = '0; pipe_data_i = '0;
    lsu_valid_i  = 1'b0; lsu_rd_i  = '0; lsu_data_i  = '0;
  endtask

  task automatic pipe(input logic [4:0] rd, input logic [31:0] data);
    pipe_valid_i = 1'b1; pipe_rd_i = rd; pipe_data_i = data;
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [31:0] data);
    lsu_valid_i = 1'b1; lsu_rd_i = rd; lsu_data_i = data;
  endtask

  task automatic out_chk(input string tag, input logic we, input logic [4:0] rd,
                         input logic [31:0] data, input logic [2:0] cnt);
    chk({tag, ".we"}, 32'(reg_write_o), 32'(we));
    chk({tag, ".rd"}, 32'(rd_addr_o), 32'(rd));
    chk({tag, ".data"}, write_data_o, data);
    chk({tag, ".count"}, 32'(fifo_count_o), 32'(cnt));
  endtask

  initial begin
    idle();
    query_addr_i = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    out_chk("reset", 1'b0, 5'd0, 32'h0, 3'd0);
    chk("reset.ready", 32'(lsu_ready_o), 32'd1);

    // Pipe write appears next cycle; x0 pipe write is idle and holds rd/data.
    pipe(5'd5, 32'hDEADBEEF);
    step();
    out_chk("pipe5", 1'b1, 5'd5, 32'hDEADBEEF, 3'd0);
    pipe(5'd0, 32'h11111111);
    step();
    out_chk("pipe0", 1'b0, 5'd5, 32'hDEADBEEF, 3'd0);

    // Bypass with empty FIFO and idle pipe.
    idle();
    lsu(5'd7, 32'h12345678);
    #1;
    chk("bypass.ready", 32'(lsu_ready_o), 32'd1);
    step();
    idle();
    out_chk("bypass", 1'b1, 5'd7, 32'h12345678, 3'd0);

    // x0 LSU completion while pipe busy: handshakes, never pushed.
    pipe(5'd20, 32'hA0);
    lsu(5'd0, 32'hBAD);
    step();
    out_chk("lsu_x0", 1'b1, 5'd20, 32'hA0, 3'd0);
    idle();

    // Starvation: pipe busy six cycles, LSU offers rd 1..5 with data 100+rd.
    begin
      int nxt = 1;
      for (int c = 0; c < 6; c++) begin
        logic acc;
        pipe(5'(20 + c), 32'(200 + c));
        lsu(5'(nxt), 32'(100 + nxt));
        #1;
        acc = lsu_ready_o;
        chk($sformatf("starve%0d.ready", c), 32'(lsu_ready_o), (c < 4) ? 32'd1 : 32'd0);
        step();
        chk($sformatf("starve%0d.rd", c), 32'(rd_addr_o), 32'(20 + c));
        if (acc) nxt++;
      end
      chk("starve.accepted", 32'(nxt - 1), 32'd4);
    end
    chk("starve.count", 32'(fifo_count_o), 32'd4);
    chk("starve.ready_low", 32'(lsu_ready_o), 32'd0);

    // Drain: pipe idles, fifth request (rd 5) held until a slot frees.
    pipe_valid_i = 1'b0; pipe_rd_i = '0;
    step();
    out_chk("drain1", 1'b1, 5'd1, 32'd101, 3'd3);
    chk("drain1.ready", 32'(lsu_ready_o), 32'd1);
    step();
    lsu_valid_i = 1'b0;
    out_chk("drain2", 1'b1, 5'd2, 32'd102, 3'd3);
    step();
    out_chk("drain3", 1'b1, 5'd3, 32'd103, 3'd2);
    step();
    out_chk("drain4", 1'b1, 5'd4, 32'd104, 3'd1);
    step();
    out_chk("drain5", 1'b1, 5'd5, 32'd105, 3'd0);
    step();
    chk("drain.idle_we", 32'(reg_write_o), 32'd0);

    // Fill two entries (rd 9, 11) behind a busy pipe, then query.
    pipe(5'd30, 32'h300);
    lsu(5'd9, 32'h900);
    step();
    lsu(5'd11, 32'hB00);
    step();
    idle();
    chk("fill.count", 32'(fifo_count_o), 32'd2);
    query_addr_i = 5'd9;  #1; chk("query9", 32'(query_hit_o), 32'd1);
    query_addr_i = 5'd10; #1; chk("query10", 32'(query_hit_o), 32'd0);
    query_addr_i = 5'd0;  #1; chk("query0", 32'(query_hit_o), 32'd0);
    query_addr_i = 5'd30; #1; chk("query_out", 32'(query_hit_o), 32'd1);
    query_addr_i = 5'd11; #1; chk("query11", 32'(query_hit_o), 32'd1);
    query_addr_i = 5'd0;

    // Simultaneous push/pop at count 2, order preserved.
    lsu(5'd12, 32'hC00);
    step();
    idle();
    out_chk("pushpop", 1'b1, 5'd9, 32'h900, 3'd2);
    step();
    out_chk("pp_next1", 1'b1, 5'd11, 32'hB00, 3'd1);
    step();
    out_chk("pp_next2", 1'b1, 5'd12, 32'hC00, 3'd0);

    // Reset mid-operation with three entries buffered.
    for (int c = 0; c < 3; c++) begin
      pipe(5'd25, 32'(250 + c));
      lsu(5'(1 + c), 32'(400 + c));
      step();
    end
    chk("premrst.count", 32'(fifo_count_o), 32'd3);
    chk("premrst.we", 32'(reg_write_o), 32'd1);
    rst = 1'b1;
    lsu(5'd8, 32'h888);
    step();
    rst = 1'b0;
    idle();
    #1;
    out_chk("midrst", 1'b0, 5'd0, 32'h0, 3'd0);
    chk("midrst.ready", 32'(lsu_ready_o), 32'd1);
    step();
    out_chk("postrst1", 1'b0, 5'd0, 32'h0, 3'd0);
    step();
    out_chk("postrst2", 1'b0, 5'd0, 32'h0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Writeback-stage arbiter directly upstream of the register file write port. Merges in-order retire writes from the MEM/WB pipeline with out-of-order completions from the long-latency load/store unit onto the register file's single write port. Buffers LSU completions in a small FIFO, filters x0 writes, and exposes a pending-write query for the hazard unit.

## Interface
- `DEPTH`, 4: LSU completion FIFO entries; power of two, 2..16.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset.
- `pipe_valid_i`  in  1  MEM/WB retire write request; always accepted, never back-pressured.
- `pipe_rd_i`  in  5  retire destination register.
- `pipe_data_i`  in  32  retire write data.
- `lsu_valid_i`  in  1  LSU completion valid.
- `lsu_ready_o`  out  1  FIFO can accept; `lsu_ready_o = (count < DEPTH)`, combinational from registered count.
- `lsu_rd_i`  in  5  LSU destination register.
- `lsu_data_i`  in  32  LSU write data.
- `reg_write_o`  out  1  to register file `reg_write_i`.
- `rd_addr_o`  out  5  to register file `rd_addr_i`.
- `write_data_o`  out  32  to register file `write_data_i`.
- `fifo_count_o`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `query_addr_i`  in  5  hazard-unit lookup address.
- `query_hit_o`  out  1  combinational: a write to `query_addr_i` is in the FIFO or in the output register.

## Operation
- Pipe request effective when `pipe_valid_i && pipe_rd_i != 0`; x0 pipe requests count as idle.
- LSU handshake completes when `lsu_valid_i && lsu_ready_o`. An accepted LSU completion with `lsu_rd_i == 0` is consumed and discarded: no FIFO push, no write.
- Per-cycle output selection, highest priority first:
  - Effective pipe request: the output register loads the pipe write.
  - FIFO non-empty: pop head into the output register.
  - FIFO empty and accepted LSU with nonzero rd: bypass straight into the output register. No push.
  - Otherwise: `reg_write_o` = 0. `rd_addr_o` and `write_data_o` hold their last value.
- Push: an accepted nonzero-rd LSU completion pushes to the FIFO tail unless it takes the bypass path.
- A push and a pop in the same cycle are legal and leave count unchanged. A push while full cannot occur because ready is low.
- FIFO pointers wrap modulo DEPTH.
- Ordering is not enforced between sources. WAW/RAW safety is the hazard unit's job via `query_hit_o`. Within the LSU source, order is strict FIFO.
- `query_hit_o` = (`query_addr_i` != 0) && (match on any valid FIFO entry || (`reg_write_o` && `rd_addr_o` == `query_addr_i`)).

## Timing
- Pipe write reaches `reg_write_o` 1 cycle after being presented.
- LSU bypass latency is 1 cycle. Buffered LSU latency is 1 cycle plus the number of pipe-busy cycles and older entries ahead of it.
- `lsu_ready_o` deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the first pop from full.
- A continuously busy pipe starves the FIFO indefinitely. This is accepted, because the pipeline drains on a stall.
- Reset, synchronous, including mid-operation:
  - `reg_write_o` = 0, `rd_addr_o` = 0, `write_data_o` = 0.
  - count = 0, pointers = 0, FIFO contents are discarded.
  - `lsu_ready_o` = 1 from the first cycle after reset.
  - Inputs in a reset cycle are ignored, including the LSU handshake.

## Structure
- Add `` `XLEN `` (32) and `` `REG_ADDR_W `` (5) to `defines.v` if they are not already there. All data and rd widths use them.
- Sub-module `wb_fifo`: synchronous FIFO with DEPTH-entry storage of {rd, data}.
  - Ports: push/pop, head output, count, and a per-entry valid/rd vector for the query compare.
- `writeback_arbiter` holds the priority mux, bypass, x0 filter, output register, and query logic.

## Test plan
- Pipe only: pipe rd=5, data 0xDEADBEEF at cycle N → `reg_write_o`=1, rd 5, data 0xDEADBEEF at N+1. Pipe rd=0 → `reg_write_o`=0.
- LSU bypass: FIFO empty, pipe idle, LSU rd=7, data 0x12345678 → handshake completes, write at N+1, `fifo_count_o` stays 0.
- Starvation and drain:
  - Pipe busy 6 cycles while LSU offers rd 1..4 → four accepted, count=4, `lsu_ready_o`=0, fifth LSU request is held.
  - Pipe goes idle → writes rd 1,2,3,4 on consecutive cycles, then the fifth request is accepted.
- Simultaneous push/pop: count=2, pipe idle, LSU push → head pops, new entry appended, count stays 2, order preserved.
- Query: entry with rd=9 in the FIFO → `query_hit_o`=1 for addr 9, 0 for addr 10, 0 for addr 0.
- Reset mid-operation: count=3 and `reg_write_o`=1, assert `rst` for 1 cycle → all outputs 0, count 0, `lsu_ready_o`=1, no stale writes afterward.
